rv_regfile_2w_sb: RTL and testbench

Parametrised integer register file for the next-generation RV core. It has two asynchronous read ports and two synchronous write ports with byte enables. Register x0 can be hard-wired to zero, and same-cycle write-to-read forwarding is optional. A per-register busy scoreboard lets the decode stage stall on registers that have an outstanding multi-cycle producer (load/divide). Port W0 is the single-cycle ALU writeback; port W1 is the long-latency writeback that retires scoreboard reservations.

---
 rtl/rv_regfile_2w_sb.sv | 121 ++++++++++++
 tb/tb_rv_regfile_2w_sb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_regfile_2w_sb.sv
// rv_regfile_2w_sb: integer register file, two async read ports, two
// byte-enabled write ports (W0 = ALU writeback, W1 = long-latency retire),
// optional hard-wired x0, optional write-through forwarding and a
// per-register busy scoreboard for stalling on outstanding producers.
module rv_regfile_2w_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              a_rst,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [XLEN-1:0]   wd0,
    input  logic [XLEN/8-1:0] wbe0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [XLEN-1:0]   wd1,
    input  logic [XLEN/8-1:0] wbe1,
    input  logic              rsv_v,
    input  logic [AW-1:0]     rsv_a
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    // Value register a will hold after this edge: W1 bytes take priority over
    // W0 bytes, bytes enabled by neither port keep the stored value.
    function automatic logic [XLEN-1:0] merge_wr(input logic [XLEN-1:0] cur,
                                                 input logic [AW-1:0]   a);
        logic [XLEN-1:0] v;
        v = cur;
        for (int b = 0; b < NB; b++) begin
            if (we1 && (wa1 == a) && wbe1[b]) begin
                v[8*b +: 8] = wd1[8*b +: 8];
            end else if (we0 && (wa0 == a) && wbe0[b]) begin
                v[8*b +: 8] = wd0[8*b +: 8];
            end
        end
        return v;
    endfunction

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    function automatic logic [XLEN-1:0] read_data(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        if (!a_rst || is_zero(a)) begin
            v = '0;
        end else if (BYPASS != 0) begin
            v = merge_wr(regs[a], a);
        end else begin
            v = regs[a];
        end
        return v;
    endfunction

    // A same-cycle W1 retire forwards its data, so the reader need not stall.
    // A same-cycle reserve only shows up after the edge.
    function automatic logic read_busy(input logic [AW-1:0] a);
        logic v;
        if (!a_rst || is_zero(a)) begin
            v = 1'b0;
        end else if ((BYPASS != 0) && we1 && (wa1 == a)) begin
            v = 1'b0;
        end else begin
            v = busy[a];
        end
        return v;
    endfunction

    // Register storage: byte-merged writes from both ports, x0 optionally frozen.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (!is_zero(AW'(i))) begin
                    regs[i] <= merge_wr(regs[i], AW'(i));
                end
            end
        end
    end

    // Scoreboard: reserve sets, W1 retire clears, reserve wins on a collision.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (rsv_v && (rsv_a == AW'(i)) && !is_zero(AW'(i))) begin
                    busy[i] <= 1'b1;
                end else if (we1 && (wa1 == AW'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Combinational read ports and busy lookups.
    always_comb begin
        rd1   = read_data(ra1);
        rd2   = read_data(ra2);
        busy1 = read_busy(ra1);
        busy2 = read_busy(ra2);
    end

endmodule

// File: tb/tb_rv_regfile_2w_sb.sv
// Testbench for rv_regfile_2w_sb: a write-through instance and a
// non-forwarding instance share all inputs. Directed table rows, a
// mid-operation reset sequence and randomized traffic against a model.
module tb_rv_regfile_2w_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            a_rst;
    logic [AW-1:0]   ra1, ra2, wa0, wa1, rsv_a;
    logic            we0, we1, rsv_v;
    logic [XLEN-1:0] wd0, wd1;
    logic [3:0]      wbe0, wbe1;
    logic [XLEN-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic            busy1_b, busy2_b, busy1_n, busy2_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv_regfile_2w_sb #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .clk(clk), .a_rst(a_rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .busy1(busy1_b), .busy2(busy2_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .wbe0(wbe0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .wbe1(wbe1),
        .rsv_v(rsv_v), .rsv_a(rsv_a)
    );

    rv_regfile_2w_sb #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1), .BYPASS(0)) dut_n (
        .clk(clk), .a_rst(a_rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
        .busy1(busy1_n), .busy2(busy2_n),
        .we0(we0), .wa0(wa0), .wd0(wd0), .wbe0(wbe0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .wbe1(wbe1),
        .rsv_v(rsv_v), .rsv_a(rsv_a)
    );

    // ---------------- reference model ----------------
    logic [XLEN-1:0] m_reg  [NREG];
    logic            m_busy [NREG];

    function automatic logic [31:0] bmask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        if (be[0]) m = m | 32'h0000_00FF;
        if (be[1]) m = m | 32'h0000_FF00;
        if (be[2]) m = m | 32'h00FF_0000;
        if (be[3]) m = m | 32'hFF00_0000;
        return m;
    endfunction

    // Apply W0 then W1 (so W1 wins overlapping bytes) to the stored value.
    function automatic logic [31:0] after_edge(input logic [AW-1:0] a);
        logic [31:0] v;
        v = m_reg[a];
        if (we0 && wa0 == a) v = (v & ~bmask(wbe0)) | (wd0 & bmask(wbe0));
        if (we1 && wa1 == a) v = (v & ~bmask(wbe1)) | (wd1 & bmask(wbe1));
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [31:0] n0, n1;
        if (!a_rst) begin
            model_reset();
        end else begin
            n0 = after_edge(wa0);
            n1 = after_edge(wa1);
            if (we0 && wa0 != 0) m_reg[wa0] = n0;
            if (we1 && wa1 != 0) m_reg[wa1] = n1;
            if (we1) m_busy[wa1] = 1'b0;
            if (rsv_v && rsv_a != 0) m_busy[rsv_a] = 1'b1;
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [AW-1:0] a, input bit bp);
        if (!a_rst || a == 0) return 32'h0;
        return bp ? after_edge(a) : m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit bp);
        if (!a_rst || a == 0) return 1'b0;
        if (bp && we1 && wa1 == a) return 1'b0;
        return m_busy[a];
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " rd1_b"},   rd1_b,   exp_rd(ra1, 1'b1));
        chk({tag, " rd2_b"},   rd2_b,   exp_rd(ra2, 1'b1));
        chk({tag, " rd1_n"},   rd1_n,   exp_rd(ra1, 1'b0));
        chk({tag, " rd2_n"},   rd2_n,   exp_rd(ra2, 1'b0));
        chk({tag, " busy1_b"}, 32'(busy1_b), 32'(exp_busy(ra1, 1'b1)));
        chk({tag, " busy2_b"}, 32'(busy2_b), 32'(exp_busy(ra2, 1'b1)));
        chk({tag, " busy1_n"}, 32'(busy1_n), 32'(exp_busy(ra1, 1'b0)));
        chk({tag, " busy2_n"}, 32'(busy2_n), 32'(exp_busy(ra2, 1'b0)));
    endtask

    task automatic idle();
        we0 = 0; wa0 = '0; wd0 = '0; wbe0 = '0;
        we1 = 0; wa1 = '0; wd1 = '0; wbe1 = '0;
        rsv_v = 0; rsv_a = '0;
    endtask

    // Inputs change 1 ns after the rising edge; the model follows the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic          we0;
        logic [AW-1:0] wa0;
        logic [31:0]   wd0;
        logic [3:0]    wbe0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [31:0]   wd1;
        logic [3:0]    wbe1;
        logic          rv;
        logic [AW-1:0] ra;
        logic [AW-1:0] rdaddr;
        logic [31:0]   e_rd_b;
        logic [31:0]   e_rd_n;
        logic          e_bz_b;
        logic          e_bz_n;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    function automatic vec_t mk(input int w0, input int a0, input logic [31:0] d0, input int be0,
                                input int w1, input int a1, input logic [31:0] d1, input int be1,
                                input int rv, input int rsa, input int r1,
                                input logic [31:0] erb, input logic [31:0] ern,
                                input int ebb, input int ebn);
        vec_t v;
        v.we0 = 1'(w0);  v.wa0 = AW'(a0); v.wd0 = d0; v.wbe0 = 4'(be0);
        v.we1 = 1'(w1);  v.wa1 = AW'(a1); v.wd1 = d1; v.wbe1 = 4'(be1);
        v.rv  = 1'(rv);  v.ra  = AW'(rsa); v.rdaddr = AW'(r1);
        v.e_rd_b = erb;  v.e_rd_n = ern;  v.e_bz_b = 1'(ebb); v.e_bz_n = 1'(ebn);
        return v;
    endfunction

    initial begin
        //              we0 wa0 wd0           be0  we1 wa1 wd1           be1  rv ra  ra1 rd_b          rd_n          bzb bzn
        tbl[0]  = mk(1, 0,  32'hDEADBEEF, 4'hF, 0, 0,  32'h0,        0,   0, 0,  0,  32'h0,        32'h0,        0, 0);
        tbl[1]  = mk(0, 0,  32'h0,        0,    0, 0,  32'h0,        0,   0, 0,  0,  32'h0,        32'h0,        0, 0);
        tbl[2]  = mk(1, 5,  32'h11223344, 4'hF, 0, 0,  32'h0,        0,   0, 0,  5,  32'h11223344, 32'h0,        0, 0);
        tbl[3]  = mk(1, 5,  32'hAABBCCDD, 4'h5, 0, 0,  32'h0,        0,   0, 0,  5,  32'h11BB33DD, 32'h11223344, 0, 0);
        tbl[4]  = mk(0, 0,  32'h0,        0,    0, 0,  32'h0,        0,   0, 0,  5,  32'h11BB33DD, 32'h11BB33DD, 0, 0);
        tbl[5]  = mk(1, 7,  32'h000000FF, 4'hF, 1, 7,  32'hABCD0000, 4'hC, 0, 0, 7,  32'hABCD00FF, 32'h0,        0, 0);
        tbl[6]  = mk(0, 0,  32'h0,        0,    0, 0,  32'h0,        0,   0, 0,  7,  32'hABCD00FF, 32'hABCD00FF, 0, 0);
        tbl[7]  = mk(1, 9,  32'h00001234, 4'hF, 0, 0,  32'h0,        0,   0, 0,  9,  32'h00001234, 32'h0,        0, 0);
        tbl[8]  = mk(0, 0,  32'h0,        0,    0, 0,  32'h0,        0,   0, 0,  9,  32'h00001234, 32'h00001234, 0, 0);
        tbl[9]  = mk(0, 0,  32'h0,        0,    0, 0,  32'h0,        0,   1, 12, 12, 32'h0,        32'h0,        0, 0);
        tbl[10] = mk(0, 0,  32'h0,        0,    0, 0,  32'h0,        0,   0, 0,  12, 32'h0,        32'h0,        1, 1);
        tbl[11] = mk(0, 0,  32'h0,        0,    1, 12, 32'h00000055, 4'hF, 0, 0, 12, 32'h00000055, 32'h0,        0, 1);
        tbl[12] = mk(0, 0,  32'h0,        0,    0, 0,  32'h0,        0,   0, 0,  12, 32'h00000055, 32'h00000055, 0, 0);
        tbl[13] = mk(0, 0,  32'h0,        0,    0, 0,  32'h0,        0,   1, 3,  3,  32'h0,        32'h0,        0, 0);
        tbl[14] = mk(0, 0,  32'h0,        0,    1, 3,  32'h00000077, 4'hF, 1, 3, 3,  32'h00000077, 32'h0,        0, 1);
        tbl[15] = mk(0, 0,  32'h0,        0,    0, 0,  32'h0,        0,   0, 0,  3,  32'h00000077, 32'h00000077, 1, 1);
        tbl[16] = mk(0, 0,  32'h0,        0,    1, 3,  32'hFFFFFFFF, 0,   0, 0,  3,  32'h00000077, 32'h00000077, 0, 1);
        tbl[17] = mk(0, 0,  32'h0,        0,    0, 0,  32'h0,        0,   0, 0,  3,  32'h00000077, 32'h00000077, 0, 0);
        tbl[18] = mk(0, 0,  32'h0,        0,    0, 0,  32'h0,        0,   1, 0,  0,  32'h0,        32'h0,        0, 0);
        tbl[19] = mk(0, 0,  32'h0,        0,    0, 0,  32'h0,        0,   0, 0,  0,  32'h0,        32'h0,        0, 0);
    end

    // ---------------- main sequence ----------------
    initial begin
        a_rst = 1'b0;
        idle();
        ra1 = '0; ra2 = '0;
        model_reset();

        // Reset held: every address reads 0 and is not busy, even with writes driven.
        we0 = 1; wa0 = 5'd4; wd0 = 32'hFFFF_FFFF; wbe0 = 4'hF;
        rsv_v = 1; rsv_a = 5'd4;
        for (int a = 0; a < NREG; a++) begin
            ra1 = AW'(a); ra2 = AW'(NREG - 1 - a);
            #3;
            chk("rst rd1_b",   rd1_b, 32'h0);
            chk("rst rd2_b",   rd2_b, 32'h0);
            chk("rst rd1_n",   rd1_n, 32'h0);
            chk("rst busy1_b", 32'(busy1_b), 32'h0);
            chk("rst busy2_n", 32'(busy2_n), 32'h0);
        end
        idle();
        @(posedge clk);
        #1;
        a_rst = 1'b1;

        // After release, storage is still all zero.
        for (int a = 0; a < NREG; a++) begin
            ra1 = AW'(a); ra2 = AW'(a ^ 1);
            #1;
            chk("post-rst rd1_n", rd1_n, 32'h0);
            chk("post-rst busy1_n", 32'(busy1_n), 32'h0);
        end
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < NV; i++) begin
            we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0; wbe0 = tbl[i].wbe0;
            we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1; wbe1 = tbl[i].wbe1;
            rsv_v = tbl[i].rv; rsv_a = tbl[i].ra;
            ra1 = tbl[i].rdaddr; ra2 = tbl[i].rdaddr;
            #2;
            chk($sformatf("vec%0d rd1_b", i),   rd1_b, tbl[i].e_rd_b);
            chk($sformatf("vec%0d rd2_n", i),   rd2_n, tbl[i].e_rd_n);
            chk($sformatf("vec%0d busy1_b", i), 32'(busy1_b), 32'(tbl[i].e_bz_b));
            chk($sformatf("vec%0d busy2_n", i), 32'(busy2_n), 32'(tbl[i].e_bz_n));
            tick();
        end

        // Mid-operation reset clears data and busy bits immediately.
        idle();
        rsv_v = 1; rsv_a = 5'd20;
        tick();
        idle();
        we0 = 1; wa0 = 5'd20; wd0 = 32'hCAFE_F00D; wbe0 = 4'hF;
        tick();
        idle();
        ra1 = 5'd20; ra2 = 5'd12;
        #2;
        chk("pre-rst rd1_n",    rd1_n, 32'hCAFE_F00D);
        chk("pre-rst busy1_n",  32'(busy1_n), 32'h1);
        chk("pre-rst rd2_b",    rd2_b, 32'h0000_0055);
        a_rst = 1'b0;
        model_reset();
        #1;
        chk("midrst rd1_b",   rd1_b, 32'h0);
        chk("midrst rd1_n",   rd1_n, 32'h0);
        chk("midrst busy1_b", 32'(busy1_b), 32'h0);
        chk("midrst busy1_n", 32'(busy1_n), 32'h0);
        chk("midrst rd2_n",   rd2_n, 32'h0);
        we0 = 1; wa0 = 5'd20; wd0 = 32'h1357_9BDF; wbe0 = 4'hF;
        rsv_v = 1; rsv_a = 5'd20;
        #1;
        chk("midrst bypass gated", rd1_b, 32'h0);
        tick();
        idle();
        a_rst = 1'b1;
        #2;
        chk("rel rd1_n",   rd1_n, 32'h0);
        chk("rel busy1_n", 32'(busy1_n), 32'h0);
        tick();

        // Randomized traffic on a narrow address range to force collisions.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                a_rst = 1'b0;
                model_reset();
            end else begin
                a_rst = 1'b1;
            end
            we0   = 1'($urandom_range(0, 1));
            wa0   = AW'($urandom_range(0, 7));
            wd0   = $urandom;
            wbe0  = 4'($urandom_range(0, 15));
            we1   = ($urandom_range(0, 2) == 0);
            wa1   = AW'($urandom_range(0, 7));
            wd1   = $urandom;
            wbe1  = 4'($urandom_range(0, 15));
            rsv_v = ($urandom_range(0, 2) == 0);
            rsv_a = AW'($urandom_range(0, 7));
            ra1   = AW'($urandom_range(0, 7));
            ra2   = ($urandom_range(0, 3) == 0) ? wa1 : AW'($urandom_range(0, 7));
            #2;
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
